// File: rtl/ram_pkg.sv
// Shared definitions for the RAM copy engine: bus widths, RAM pin encodings,
// command modes and the engine state encoding.
package ram_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_LEN_W  = 11;

    // RAM rw pin encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Command mode encoding
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ram_addr_gen.sv
// Base-plus-offset address generator. Holds the stream base, a byte offset
// and the command length. Produces the current and following wrapped
// addresses and flags the final byte of the stream. While `load` is high the
// current address is taken straight from `base`, so the very first access can
// be issued on the same edge that captures the command.
module ram_addr_gen
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int LEN_W  = RAM_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  count,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_next,
    output logic              last
);

    localparam logic [LEN_W-1:0]  ONE_LEN  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] base_r;
    logic [LEN_W-1:0]  offset_r;
    logic [LEN_W-1:0]  count_r;
    logic [ADDR_W-1:0] sum_s;

    // Capture base and length on load, advance the offset once per byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_r   <= {ADDR_W{1'b0}};
            offset_r <= {LEN_W{1'b0}};
            count_r  <= {LEN_W{1'b0}};
        end else if (load) begin
            base_r   <= base;
            offset_r <= {LEN_W{1'b0}};
            count_r  <= count;
        end else if (inc) begin
            offset_r <= offset_r + ONE_LEN;
        end
    end

    // Address arithmetic is ADDR_W bits wide, so it wraps at the top of RAM.
    assign sum_s     = base_r + offset_r[ADDR_W-1:0];
    assign addr      = load ? base : sum_s;
    assign addr_next = addr + ONE_ADDR;
    assign last      = ((offset_r + ONE_LEN) == count_r);

endmodule

// File: rtl/ram_copy_engine.sv
// RAM copy/fill engine. Takes one command per start strobe and moves or
// fills a block of bytes in the single-port RAM on its own. Copy alternates
// a read cycle and a write cycle per byte; fill writes one byte per cycle.
// Every output comes straight from a flop.
module ram_copy_engine
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int LEN_W  = RAM_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  bytes_done,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);
    localparam logic [LEN_W-1:0] ONE_LEN = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state_r, state_next_s;
    logic              mode_r;
    logic [DATA_W-1:0] fill_r;

    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [LEN_W-1:0]  bytes_done_r, bytes_done_s;
    logic              mem_en_r, mem_en_s;
    logic              mem_rw_r, mem_rw_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

    logic              load_s;
    logic              inc_s;
    logic [LEN_W-1:0]  len_eff_s;
    logic [ADDR_W-1:0] src_cur_s, src_next_s, dst_cur_s, dst_next_s;
    logic              src_last_s, dst_last_s, last_s;

    // A command is accepted only from IDLE; both streams step after each write.
    assign load_s    = (state_r == IDLE) && start;
    assign inc_s     = (state_r == WR);
    assign len_eff_s = (len > MAX_LEN) ? MAX_LEN : len;
    // Both counters advance in lockstep; take the terminal flag from the
    // stream that actually drives the reads (copy) or writes (fill).
    assign last_s    = (mode_r == MODE_FILL) ? dst_last_s : src_last_s;

    ram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_src_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .base      (src_addr),
        .count     (len_eff_s),
        .inc       (inc_s),
        .addr      (src_cur_s),
        .addr_next (src_next_s),
        .last      (src_last_s)
    );

    ram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_dst_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .base      (dst_addr),
        .count     (len_eff_s),
        .inc       (inc_s),
        .addr      (dst_cur_s),
        .addr_next (dst_next_s),
        .last      (dst_last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the command mode and fill pattern when a command is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_r <= MODE_COPY;
            fill_r <= {DATA_W{1'b0}};
        end else if (load_s) begin
            mode_r <= mode;
            fill_r <= fill_data;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_next_s = state_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        bytes_done_s = bytes_done_r;
        mem_en_s     = mem_en_r;
        mem_rw_s     = mem_rw_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        case (state_r)
            IDLE: begin
                busy_s   = 1'b0;
                mem_en_s = 1'b0;
                if (start) begin
                    bytes_done_s = {LEN_W{1'b0}};
                    if (len_eff_s == {LEN_W{1'b0}}) begin
                        state_next_s = DONE;
                    end else if (mode == MODE_FILL) begin
                        state_next_s = WR;
                        busy_s       = 1'b1;
                        mem_en_s     = 1'b1;
                        mem_rw_s     = RW_WRITE;
                        mem_addr_s   = dst_cur_s;
                        mem_wdata_s  = fill_data;
                    end else begin
                        state_next_s = RD;
                        busy_s       = 1'b1;
                        mem_en_s     = 1'b1;
                        mem_rw_s     = RW_READ;
                        mem_addr_s   = src_cur_s;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD: begin
                // Read data is valid now; it becomes the write data.
                state_next_s = WR;
                mem_en_s     = 1'b1;
                mem_rw_s     = RW_WRITE;
                mem_addr_s   = dst_cur_s;
                mem_wdata_s  = mem_rdata;
            end
            WR: begin
                bytes_done_s = bytes_done_r + ONE_LEN;
                if (last_s) begin
                    state_next_s = DONE;
                    busy_s       = 1'b0;
                    mem_en_s     = 1'b0;
                    mem_rw_s     = RW_READ;
                end else if (mode_r == MODE_FILL) begin
                    state_next_s = WR;
                    mem_addr_s   = dst_next_s;
                    mem_wdata_s  = fill_r;
                end else begin
                    state_next_s = RD;
                    mem_rw_s     = RW_READ;
                    mem_addr_s   = src_next_s;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                done_s       = 1'b1;
                busy_s       = 1'b0;
                mem_en_s     = 1'b0;
            end
            default: begin
                state_next_s = IDLE;
                busy_s       = 1'b0;
                mem_en_s     = 1'b0;
                mem_rw_s     = RW_READ;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            bytes_done_r <= {LEN_W{1'b0}};
            mem_en_r     <= 1'b0;
            mem_rw_r     <= RW_READ;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
        end else begin
            busy_r       <= busy_s;
            done_r       <= done_s;
            bytes_done_r <= bytes_done_s;
            mem_en_r     <= mem_en_s;
            mem_rw_r     <= mem_rw_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign bytes_done = bytes_done_r;
    assign mem_en     = mem_en_r;
    assign mem_rw     = mem_rw_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a negedge-sampling RAM model and a
// shadow byte array updated in ascending order for every command.
module tb_ram_copy_engine;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int LW = 11;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic [DW-1:0] fill_data;
    logic          busy;
    logic          done;
    logic [LW-1:0] bytes_done;
    logic          mem_en;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    ram_copy_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill_data  (fill_data),
        .busy       (busy),
        .done       (done),
        .bytes_done (bytes_done),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model and backdoor preload port
    logic [7:0]    ram   [1024];
    logic [7:0]    model [1024];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_data;
    int            rd_total  = 0;
    int            wr_total  = 0;
    int            acc_total = 0;
    logic [AW:0]   acc_log [64];

    // RAM samples en/rw/addr/data on negedge; read data appears for the next posedge.
    always @(negedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_en) begin
            if (mem_rw) begin
                mem_rdata <= ram[mem_addr];
                rd_total  <= rd_total + 1;
            end else begin
                ram[mem_addr] <= mem_wdata;
                wr_total      <= wr_total + 1;
            end
            acc_log[acc_total[5:0]] <= {mem_rw, mem_addr};
            acc_total <= acc_total + 1;
        end else begin
            mem_rdata <= 8'hxx;
        end
    end

    typedef struct {
        logic          m;
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        logic [LW-1:0] l;
        logic [7:0]    f;
        int            lat;
        int            bsy;
        int            bytes;
        int            rds;
        int            wrs;
    } vec_t;

    vec_t        vecs [8];
    logic [AW:0] wrap_exp [6];
    int          tests = 0;
    int          fails = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] v);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = v;
        model[a] = v;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic model_apply(input vec_t vc);
        int n;
        logic [AW-1:0] sa;
        logic [AW-1:0] da;
        n = (vc.l > 11'd1024) ? 1024 : int'(vc.l);
        for (int i = 0; i < n; i++) begin
            sa = vc.s + AW'(i);
            da = vc.d + AW'(i);
            model[da] = vc.m ? vc.f : model[sa];
        end
    endtask

    task automatic check_ram(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (ram[i] !== model[i]) bad++;
        end
        check(nm, bad, 0);
    endtask

    task automatic run_cmd(input vec_t vc, output int lat, output int bcyc,
                           output int dnext, output int bd);
        start     = 1'b1;
        mode      = vc.m;
        src_addr  = vc.s;
        dst_addr  = vc.d;
        len       = vc.l;
        fill_data = vc.f;
        tick();
        start = 1'b0;
        lat   = 0;
        bcyc  = 0;
        while (done !== 1'b1 && lat < 3000) begin
            if (busy === 1'b1) bcyc++;
            tick();
            lat++;
        end
        bd = int'(bytes_done);
        tick();
        dnext = int'(done);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rd0, wr0, a0, lat, bcyc, dnext, bd, w, dseen, ens;
        vec_t vc;

        //               mode  src      dst      len      fill   lat   bsy   bytes rds  wrs
        vecs[0] = '{1'b0, 10'd200,  10'd500,  11'd3,    8'h00, 7,    6,    3,    3,   3};
        vecs[1] = '{1'b1, 10'd0,    10'd13,   11'd4,    8'hA5, 5,    4,    4,    0,   4};
        vecs[2] = '{1'b0, 10'd1022, 10'd1023, 11'd3,    8'h00, 7,    6,    3,    3,   3};
        vecs[3] = '{1'b1, 10'd0,    10'd40,   11'd0,    8'h77, 1,    0,    0,    0,   0};
        vecs[4] = '{1'b1, 10'd0,    10'd1020, 11'd8,    8'h3C, 9,    8,    8,    0,   8};
        vecs[5] = '{1'b0, 10'd10,   10'd8,    11'd4,    8'h00, 9,    8,    4,    4,   4};
        vecs[6] = '{1'b0, 10'd5,    10'd6,    11'd1,    8'h00, 3,    2,    1,    1,   1};
        vecs[7] = '{1'b1, 10'd0,    10'd0,    11'd2000, 8'h5A, 1025, 1024, 1024, 0,   1024};
        wrap_exp[0] = {1'b1, 10'd1022};
        wrap_exp[1] = {1'b0, 10'd1023};
        wrap_exp[2] = {1'b1, 10'd1023};
        wrap_exp[3] = {1'b0, 10'd0};
        wrap_exp[4] = {1'b1, 10'd0};
        wrap_exp[5] = {1'b0, 10'd1};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        repeat (3) tick();

        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_bytes", int'(bytes_done), 0);
        check("rst_en", int'(mem_en), 0);
        check("rst_rw", int'(mem_rw), 1);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);

        for (int i = 0; i < 1024; i++) bd_write(AW'(i), 8'(i * 37 + 5));
        rst_n = 1'b1;
        tick();

        // Reset after the first byte of a 5-byte copy
        for (int j = 0; j < 5; j++) begin
            bd_write(AW'(300 + j), 8'(11 * (j + 1)));
            bd_write(AW'(600 + j), 8'hEE);
        end
        wr0 = wr_total;
        start = 1'b1; mode = 1'b0; src_addr = 10'd300; dst_addr = 10'd600; len = 11'd5;
        tick();
        start = 1'b0;
        w = 0;
        while (bytes_done !== 11'd1 && w < 10) begin
            tick();
            w++;
        end
        check("mid_byte1_reached", int'(bytes_done), 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_bytes", int'(bytes_done), 0);
        check("mid_rst_en", int'(mem_en), 0);
        check("mid_rst_rw", int'(mem_rw), 1);
        check("mid_rst_addr", int'(mem_addr), 0);
        check("mid_rst_wdata", int'(mem_wdata), 0);
        rst_n = 1'b1;
        dseen = 0;
        ens   = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done === 1'b1) dseen++;
            if (mem_en === 1'b1) ens++;
        end
        check("mid_no_done", dseen, 0);
        check("mid_idle_en", ens, 0);
        check("mid_writes", wr_total - wr0, 1);
        model[600] = 8'd11;
        check_ram("mid_ram");

        // Table-driven commands
        for (int v = 0; v < 8; v++) begin
            vc = vecs[v];
            if (v == 0) begin
                bd_write(10'd200, 8'd130);
                bd_write(10'd201, 8'd52);
                bd_write(10'd202, 8'd7);
            end
            if (v == 2) begin
                bd_write(10'd1022, 8'd1);
                bd_write(10'd1023, 8'd2);
                bd_write(10'd0, 8'd3);
            end
            rd0 = rd_total;
            wr0 = wr_total;
            a0  = acc_total;
            model_apply(vc);
            run_cmd(vc, lat, bcyc, dnext, bd);
            check($sformatf("v%0d_latency", v), lat, vc.lat);
            check($sformatf("v%0d_busy_cycles", v), bcyc, vc.bsy);
            check($sformatf("v%0d_bytes_done", v), bd, vc.bytes);
            check($sformatf("v%0d_done_width", v), dnext, 0);
            check($sformatf("v%0d_reads", v), rd_total - rd0, vc.rds);
            check($sformatf("v%0d_writes", v), wr_total - wr0, vc.wrs);
            check_ram($sformatf("v%0d_ram", v));
            if (v == 2) begin
                for (int j = 0; j < 6; j++) begin
                    check($sformatf("wrap_access%0d", j),
                          int'(acc_log[(a0 + j) % 64]), int'(wrap_exp[j]));
                end
                check("wrap_ram1023", int'(ram[1023]), 1);
                check("wrap_ram0", int'(ram[0]), 1);
                check("wrap_ram1", int'(ram[1]), 1);
            end
        end

        // Second start while a copy is running must be ignored
        for (int j = 0; j < 4; j++) bd_write(AW'(100 + j), 8'(j + 1));
        vc = '{1'b0, 10'd100, 10'd700, 11'd4, 8'h00, 9, 8, 4, 4, 4};
        model_apply(vc);
        wr0 = wr_total;
        start = 1'b1; mode = 1'b0; src_addr = 10'd100; dst_addr = 10'd700; len = 11'd4;
        tick();
        dseen = 0;
        lat   = -1;
        for (int c = 1; c <= 15; c++) begin
            if (c == 3) begin
                start = 1'b1; mode = 1'b1; dst_addr = 10'd710; len = 11'd2; fill_data = 8'hC3;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) begin
                dseen++;
                if (lat < 0) lat = c;
            end
        end
        check("busy_start_done_pulses", dseen, 1);
        check("busy_start_latency", lat, 9);
        check("busy_start_writes", wr_total - wr0, 4);
        check_ram("busy_start_ram");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
